// File: rtl/wasm_memory_sram_if.sv
// Shared types for the WebAssembly linear memory plus the CPU-side request/response bus.
package wasm_memory_sram_pkg;

  localparam int unsigned MEMORY_PAGES = 2;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_t;

  typedef enum logic [3:0] {
    OP_DEFAULT = 4'd0,
    OP_I32     = 4'd1,
    OP_I64     = 4'd2,
    OP_F32     = 4'd3,
    OP_F64     = 4'd4,
    OP_I8_S    = 4'd5,
    OP_I8_U    = 4'd6,
    OP_I16_S   = 4'd7,
    OP_I16_U   = 4'd8,
    OP_I32_S   = 4'd9,
    OP_I32_U   = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE          = 2'd0,
    TRAP_OUT_OF_BOUNDS = 2'd1,
    TRAP_UNREACHABLE   = 2'd2,
    TRAP_DIV_ZERO      = 2'd3
  } trap_t;

endpackage

interface wasm_memory_sram_if;
  import wasm_memory_sram_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  mem_size_t   req_size;
  mem_op_t     req_op;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  trap_t       trap;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_op, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, trap
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_op, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error, trap
  );

endinterface

// File: rtl/wasm_memory_sram.sv
// WebAssembly linear memory on a byte-enabled synchronous SRAM: split unaligned
// accesses, bounds checking, and a one-word-per-cycle zero-fill engine for init/grow.
module wasm_memory_sram
  import wasm_memory_sram_pkg::*;
#(
  parameter int unsigned MAX_PAGES  = MEMORY_PAGES,
  parameter int unsigned PAGE_BYTES = 65536,
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wasm_memory_sram_if.slave     bus,
  input  logic                  init_valid,
  input  logic [31:0]           init_pages,
  input  logic [31:0]           init_max_pages,
  input  logic                  grow_valid,
  input  logic [31:0]           grow_pages,
  output logic                  grow_done,
  output logic [31:0]           grow_result,
  output logic [31:0]           current_pages,
  output logic                  busy,
  input  logic                  data_wr_en,
  input  logic [31:0]           data_wr_addr,
  input  logic [7:0]            data_wr_data,
  input  logic                  dbg_rd_en,
  input  logic [31:0]           dbg_rd_addr,
  output logic                  dbg_rd_valid,
  output logic [31:0]           dbg_rd_data
);

  localparam int unsigned WB             = WORD_BYTES * 8;
  localparam int unsigned OFFW           = $clog2(WORD_BYTES);
  localparam int unsigned WORDS_PER_PAGE = PAGE_BYTES / WORD_BYTES;
  localparam int unsigned DEPTH          = MAX_PAGES * WORDS_PER_PAGE;
  localparam int unsigned AW             = $clog2(DEPTH);
  localparam int unsigned CW             = AW + 1;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, RESP, FILL} state_t;

  function automatic logic [3:0] size_bytes(input mem_size_t sz);
    return 4'(4'd1 << sz);
  endfunction

  function automatic logic [3:0] op_bytes(input mem_op_t op, input mem_size_t sz);
    case (op)
      OP_I8_S, OP_I8_U:                     return 4'd1;
      OP_I16_S, OP_I16_U:                   return 4'd2;
      OP_I32, OP_F32, OP_I32_S, OP_I32_U:   return 4'd4;
      OP_I64, OP_F64:                       return 4'd8;
      default:                              return size_bytes(sz);
    endcase
  endfunction

  function automatic logic in_bounds(input logic [31:0] addr, input logic [3:0] bytes,
                                     input logic [31:0] pages);
    return (64'(addr) + 64'(bytes)) <= (64'(pages) * 64'(PAGE_BYTES));
  endfunction

  function automatic logic is_split(input logic [OFFW-1:0] off, input logic [3:0] bytes);
    return (5'(off) + 5'(bytes)) > 5'(WORD_BYTES);
  endfunction

  // Word count for a page count, capped at the physical SRAM depth.
  function automatic logic [CW-1:0] words_of(input logic [32:0] pages);
    logic [63:0] w;
    w = 64'(pages) * 64'(WORDS_PER_PAGE);
    return (w > 64'(DEPTH)) ? CW'(DEPTH) : CW'(w);
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] raw, input mem_op_t op,
                                         input logic [3:0] bytes);
    logic [63:0] mask;
    mask = (64'd1 << {bytes, 3'b000}) - 64'd1;
    case (op)
      OP_I8_S:  return {{56{raw[7]}}, raw[7:0]};
      OP_I16_S: return {{48{raw[15]}}, raw[15:0]};
      OP_I32_S: return {{32{raw[31]}}, raw[31:0]};
      default:  return raw & mask;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic                dbg_q, dbg_d;
  logic                oob_q, oob_d;
  logic                split_q, split_d;
  mem_op_t             op_q, op_d;
  logic [3:0]          bytes_q, bytes_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic [AW-1:0]       word_q, word_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [WB-1:0]       lo_q, lo_d;
  logic [31:0]         cur_pages_q, cur_pages_d;
  logic [31:0]         max_pages_q, max_pages_d;
  logic [31:0]         new_pages_q, new_pages_d;
  logic                grow_pend_q, grow_pend_d;
  logic [CW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]       fill_end_q, fill_end_d;
  logic                resp_valid_q, resp_valid_d;
  logic [63:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  trap_t               trap_q, trap_d;
  logic                grow_done_q, grow_done_d;
  logic [31:0]         grow_result_q, grow_result_d;
  logic                dbg_valid_q, dbg_valid_d;
  logic [31:0]         dbg_data_q, dbg_data_d;

  logic                  sram_en, sram_we;
  logic [WORD_BYTES-1:0] sram_be;
  logic [AW-1:0]         sram_addr;
  logic [WB-1:0]         sram_wdata;
  logic [WB-1:0]         sram_rdata;
  logic [WB-1:0]         mem [0:DEPTH-1];

  logic [3:0]            req_bytes;
  logic                  req_ib, dbg_ib, data_ib;
  logic [32:0]           grow_new;
  logic [CW-1:0]         init_words, grow_start, grow_end;
  logic [2*WB-1:0]       st_data, rd_cat;
  logic [2*WORD_BYTES-1:0] st_be;
  logic [63:0]           load_raw;

  assign req_bytes  = bus.req_write ? size_bytes(bus.req_size) : op_bytes(bus.req_op, bus.req_size);
  assign req_ib     = in_bounds(bus.req_addr, req_bytes, cur_pages_q);
  assign dbg_ib     = in_bounds(dbg_rd_addr, 4'd4, cur_pages_q);
  assign data_ib    = in_bounds(data_wr_addr, 4'd1, cur_pages_q);
  assign grow_new   = 33'(cur_pages_q) + 33'(grow_pages);
  assign init_words = words_of(33'(init_pages));
  assign grow_start = words_of(33'(cur_pages_q));
  assign grow_end   = words_of(grow_new);

  // Store lanes and byte enables across the (up to) two touched words.
  assign st_data = (2*WB)'(wdata_q) << {off_q, 3'b000};
  assign st_be   = (2*WORD_BYTES)'((9'd1 << bytes_q) - 9'd1) << off_q;

  // Little-endian load assembly: low word was captured in ACC1 when split.
  assign rd_cat   = split_q ? {sram_rdata, lo_q} : {{WB{1'b0}}, sram_rdata};
  assign load_raw = 64'(rd_cat >> {off_q, 3'b000});

  assign bus.req_ready  = (state_q == IDLE) && !init_valid && !grow_valid && !data_wr_en;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;
  assign bus.trap       = trap_q;
  assign grow_done      = grow_done_q;
  assign grow_result    = grow_result_q;
  assign current_pages  = cur_pages_q;
  assign busy           = (state_q == FILL);
  assign dbg_rd_valid   = dbg_valid_q;
  assign dbg_rd_data    = dbg_data_q;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    dbg_d         = dbg_q;
    oob_d         = oob_q;
    split_d       = split_q;
    op_d          = op_q;
    bytes_d       = bytes_q;
    off_d         = off_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    lo_d          = lo_q;
    cur_pages_d   = cur_pages_q;
    max_pages_d   = max_pages_q;
    new_pages_d   = new_pages_q;
    grow_pend_d   = grow_pend_q;
    fill_ptr_d    = fill_ptr_q;
    fill_end_d    = fill_end_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_error_d  = 1'b0;
    trap_d        = TRAP_NONE;
    grow_done_d   = 1'b0;
    grow_result_d = grow_result_q;
    dbg_valid_d   = 1'b0;
    dbg_data_d    = '0;
    sram_en       = 1'b0;
    sram_we       = 1'b0;
    sram_be       = '0;
    sram_addr     = '0;
    sram_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (init_valid) begin
          cur_pages_d = init_pages;
          max_pages_d = (init_max_pages == 32'd0) ? 32'(MAX_PAGES) : init_max_pages;
          grow_pend_d = 1'b0;
          fill_ptr_d  = '0;
          fill_end_d  = init_words;
          if (init_words != '0) state_d = FILL;
        end else if (grow_valid) begin
          if (grow_new > 33'(max_pages_q) || grow_new > 33'(MAX_PAGES)) begin
            grow_done_d   = 1'b1;
            grow_result_d = 32'hFFFF_FFFF;
          end else if (grow_pages == 32'd0) begin
            grow_done_d   = 1'b1;
            grow_result_d = cur_pages_q;
          end else begin
            new_pages_d = 32'(grow_new);
            grow_pend_d = 1'b1;
            fill_ptr_d  = grow_start;
            fill_end_d  = grow_end;
            state_d     = FILL;
          end
        end else if (data_wr_en) begin
          if (data_ib) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = data_wr_addr[AW+OFFW-1:OFFW];
            sram_be    = WORD_BYTES'(1) << data_wr_addr[OFFW-1:0];
            sram_wdata = {WORD_BYTES{data_wr_data}};
          end
        end else if (bus.req_valid) begin
          write_d = bus.req_write;
          dbg_d   = 1'b0;
          oob_d   = !req_ib;
          split_d = req_ib && is_split(bus.req_addr[OFFW-1:0], req_bytes);
          op_d    = bus.req_op;
          bytes_d = req_bytes;
          off_d   = bus.req_addr[OFFW-1:0];
          word_d  = bus.req_addr[AW+OFFW-1:OFFW];
          wdata_d = bus.req_wdata;
          state_d = req_ib ? ACC0 : RESP;
        end else if (dbg_rd_en) begin
          // Out-of-range debug reads keep normal latency but skip the SRAM.
          write_d = 1'b0;
          dbg_d   = 1'b1;
          oob_d   = !dbg_ib;
          split_d = dbg_ib && is_split(dbg_rd_addr[OFFW-1:0], 4'd4);
          op_d    = OP_I32_U;
          bytes_d = 4'd4;
          off_d   = dbg_rd_addr[OFFW-1:0];
          word_d  = dbg_rd_addr[AW+OFFW-1:OFFW];
          state_d = ACC0;
        end
      end

      ACC0: begin
        sram_en    = !oob_q;
        sram_we    = write_q;
        sram_addr  = word_q;
        sram_be    = st_be[WORD_BYTES-1:0];
        sram_wdata = st_data[WB-1:0];
        state_d    = split_q ? ACC1 : RESP;
      end

      ACC1: begin
        sram_en    = 1'b1;
        sram_we    = write_q;
        sram_addr  = word_q + AW'(1);
        sram_be    = st_be[2*WORD_BYTES-1:WORD_BYTES];
        sram_wdata = st_data[2*WB-1:WB];
        lo_d       = sram_rdata;
        state_d    = RESP;
      end

      RESP: begin
        if (dbg_q) begin
          dbg_valid_d = 1'b1;
          dbg_data_d  = oob_q ? 32'd0 : 32'(load_raw);
        end else begin
          resp_valid_d = 1'b1;
          resp_error_d = oob_q;
          trap_d       = oob_q ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;
          resp_rdata_d = (oob_q || write_q) ? 64'd0 : extend(load_raw, op_q, bytes_q);
        end
        state_d = IDLE;
      end

      FILL: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = AW'(fill_ptr_q);
        sram_be    = '1;
        sram_wdata = '0;
        fill_ptr_d = fill_ptr_q + CW'(1);
        if ((fill_ptr_q + CW'(1)) == fill_end_q) begin
          state_d = IDLE;
          if (grow_pend_q) begin
            cur_pages_d   = new_pages_q;
            grow_done_d   = 1'b1;
            grow_result_d = cur_pages_q;
            grow_pend_d   = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      dbg_q         <= 1'b0;
      oob_q         <= 1'b0;
      split_q       <= 1'b0;
      op_q          <= OP_DEFAULT;
      bytes_q       <= '0;
      off_q         <= '0;
      word_q        <= '0;
      wdata_q       <= '0;
      lo_q          <= '0;
      cur_pages_q   <= '0;
      max_pages_q   <= 32'(MAX_PAGES);
      new_pages_q   <= '0;
      grow_pend_q   <= 1'b0;
      fill_ptr_q    <= '0;
      fill_end_q    <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
      trap_q        <= TRAP_NONE;
      grow_done_q   <= 1'b0;
      grow_result_q <= '0;
      dbg_valid_q   <= 1'b0;
      dbg_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      dbg_q         <= dbg_d;
      oob_q         <= oob_d;
      split_q       <= split_d;
      op_q          <= op_d;
      bytes_q       <= bytes_d;
      off_q         <= off_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      lo_q          <= lo_d;
      cur_pages_q   <= cur_pages_d;
      max_pages_q   <= max_pages_d;
      new_pages_q   <= new_pages_d;
      grow_pend_q   <= grow_pend_d;
      fill_ptr_q    <= fill_ptr_d;
      fill_end_q    <= fill_end_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      trap_q        <= trap_d;
      grow_done_q   <= grow_done_d;
      grow_result_q <= grow_result_d;
      dbg_valid_q   <= dbg_valid_d;
      dbg_data_q    <= dbg_data_d;
    end
  end

  // Single-port SRAM macro model: byte-enabled write, registered read.
  always_ff @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

endmodule
